muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative signed multiply/divide sequencer for the multicycle MIPS core.
- Sits between the A/B operand registers and the HI/LO registers; the control unit pulses start for MULT/DIV and stalls until done.
- Computes HI/LO over 34 clock edges using a shared 32-step shift/add–subtract engine, and flags divide-by-zero for the exception path (EPC/vector).

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH bits each; iteration count = WIDTH.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = MULT, 1 = DIV (sampled with start).
- a  in  WIDTH  signed multiplicand or dividend (RegA).
- b  in  WIDTH  signed multiplier or divisor (RegB).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse; DIV with b = 0.
- hi  out  WIDTH  HI result; product[63:32] or remainder.
- lo  out  WIDTH  LO result; product[31:0] or quotient.

Behaviour:
- Reset values: busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, state = IDLE, counter = 0.
- Async reset mid-operation aborts immediately. No partial result reaches hi/lo; they read 0.
- States: IDLE, PREP, RUN, FIX. done and div_zero are registered pulses.
- IDLE, start = 1 at edge E0:
  - If op = DIV and b = 0: stay in IDLE, pulse done = 1 and div_zero = 1 for exactly one cycle after E0. hi/lo keep their prior values; busy stays 0.
  - Otherwise: latch op, a, b and the result signs, then go to PREP with busy = 1.
- PREP (E1): load unsigned magnitudes |a| and |b| (via two's complement), clear the accumulator and counter, then go to RUN.
- RUN (E2..E33): exactly WIDTH iterations; at E33 (counter = WIDTH−1) go to FIX.
  - MULT: shift-add on a 2·WIDTH accumulator.
  - DIV: restoring shift-subtract; the remainder register is WIDTH+1 bits.
- FIX (E34): apply signs and write hi/lo, then go to IDLE. busy drops and done = 1 for one cycle after E34.
  - MULT: 64-bit product is negated if sign(a) ≠ sign(b).
  - DIV: quotient is negated if the signs differ (truncation toward zero); remainder takes the sign of the dividend.
- Latency is 34 edges from start sampling to hi/lo/done valid. hi/lo hold until the next completion or reset.
- Corner cases:
  - −2^31 × −2^31 gives hi = 0x40000000, lo = 0.
  - −2^31 ÷ −1 gives lo = 0x80000000, hi = 0 (wraps; no overflow flag).
- Input hold and ignored requests:
  - start while busy is ignored; no queueing.
  - a, b and op may change after E0 without effect.
  - start asserted in the done cycle begins a new operation; done and busy may then both be 1 for that cycle.
- MFHI/MFLO read hi/lo combinationally; there are no write-enable ports.

Test Plan:
- Reset check: assert reset mid-RUN of MULT 7×3 → busy, done, hi and lo read 0 immediately, without waiting for a clock edge. After release, the next start completes normally.
- MULT −5 × 6 → done exactly 34 edges after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFE2. busy is high for 34 cycles.
- DIV −7 ÷ 2 → lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1). Then DIV 100 ÷ −7 → lo = 0xFFFFFFF2, hi = 0x00000002.
- DIV 5 ÷ 0 with prior hi = 0x11, lo = 0x22:
  - done and div_zero pulse one cycle after start; busy is never asserted.
  - hi/lo remain 0x11/0x22.
- Corner values:
  - MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
  - DIV 0x80000000 ÷ 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- start re-pulsed at cycles 5 and 20 of a MULT with changed a/b → ignored; the result matches the original operands. Back-to-back start in the done cycle → second result after a further 34 edges.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative signed MULT/DIV sequencer for the multicycle MIPS core.
// One shared 32-step engine: shift-add for MULT, restoring shift-subtract for DIV.
module muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PREP = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] FIX  = 2'd3;

   logic [1:0]         state;
   logic [CNT_W-1:0]   count;
   logic               opDiv, negRes, negRem;
   logic [WIDTH-1:0]   opA, opB;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     rem;

   logic [WIDTH-1:0]   magA, magB;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH+1:0]   diff;
   logic [2*WIDTH-1:0] prodSigned;
   logic [WIDTH-1:0]   quoSigned, remSigned;

   // acc holds {partial product, multiplier} for MULT and {0, dividend/quotient} for DIV
   always_comb begin
      magA       = opA[WIDTH-1] ? -opA : opA;
      magB       = opB[WIDTH-1] ? -opB : opB;
      mulSum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & opA};
      shifted    = {rem[WIDTH-1:0], acc[WIDTH-1]};
      diff       = {rem, acc[WIDTH-1]} - {2'b00, opB};
      prodSigned = negRes ? -acc : acc;
      quoSigned  = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      remSigned  = negRem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         opDiv    <= 1'b0;
         negRes   <= 1'b0;
         negRem   <= 1'b0;
         opA      <= '0;
         opB      <= '0;
         acc      <= '0;
         rem      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (op && (b == '0)) begin
                     done     <= 1'b1;
                     div_zero <= 1'b1;
                  end else begin
                     opDiv  <= op;
                     opA    <= a;
                     opB    <= b;
                     negRes <= a[WIDTH-1] ^ b[WIDTH-1];
                     negRem <= a[WIDTH-1];
                     busy   <= 1'b1;
                     state  <= PREP;
                  end
               end
            end
            PREP: begin
               opA   <= magA;
               opB   <= magB;
               acc   <= {{WIDTH{1'b0}}, (opDiv ? magA : magB)};
               rem   <= '0;
               count <= '0;
               state <= RUN;
            end
            RUN: begin
               if (opDiv) begin
                  // restore when the trial subtraction goes negative
                  rem <= diff[WIDTH+1] ? shifted : diff[WIDTH:0];
                  acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH+1]};
               end else begin
                  acc <= {mulSum, acc[WIDTH-1:1]};
               end
               count <= count + 1'b1;
               if (count == CNT_W'(WIDTH - 1))
                  state <= FIX;
            end
            FIX: begin
               if (opDiv) begin
                  hi <= remSigned;
                  lo <= quoSigned;
               end else begin
                  hi <= prodSigned[2*WIDTH-1:WIDTH];
                  lo <= prodSigned[WIDTH-1:0];
               end
               count <= '0;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, signed results, div-by-zero,
// async abort, ignored restarts and back-to-back issue.
module tb_muldiv_seq;
   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset, start, op;
   logic [W-1:0] a, b;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;
   int           nCmp = 0, nErr = 0;
   int           n, bc;

   always #5 clock = ~clock;

   muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nCmp++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // present a request for one edge, then scramble the operands
   task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clock);
      start = 1'b0; op = ~o; a = ~x; b = ~y;
   endtask

   // called at the negedge after the sampling edge; n = edges until done is seen
   task automatic waitDone(input bit repulse, output int nEdge, output int nBusy);
      nEdge = 0; nBusy = 0;
      while (!done && nEdge < 100) begin
         if (busy) nBusy++;
         if (repulse) begin
            start = (nEdge == 5 || nEdge == 20);
            if (start) begin op = 1'b1; a = 32'd99; b = 32'd99; end
         end
         @(negedge clock);
         nEdge++;
      end
      start = 1'b0;
   endtask

   task automatic runOp(input string tag, input logic o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eHi, input logic [W-1:0] eLo);
      @(negedge clock);
      issue(o, x, y);
      waitDone(1'b0, n, bc);
      chk({tag, "/latency"}, 64'(n), 64'd34);
      chk({tag, "/hi"}, 64'(hi), 64'(eHi));
      chk({tag, "/lo"}, 64'(lo), 64'(eLo));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clock);
      chk("rst/busy", 64'(busy), 64'd0);
      chk("rst/done", 64'(done), 64'd0);
      chk("rst/divz", 64'(div_zero), 64'd0);
      chk("rst/hilo", {hi, lo}, 64'd0);
      reset = 1'b0;

      runOp("mul_m5x6", 1'b0, 32'hFFFFFFFB, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFE2);
      chk("mul_m5x6/busycyc", 64'(bc), 64'd34);
      chk("mul_m5x6/busyoff", 64'(busy), 64'd0);
      @(negedge clock);
      chk("mul_m5x6/donepulse", 64'(done), 64'd0);

      // async abort mid-RUN, checked between clock edges
      @(negedge clock);
      issue(1'b0, 32'd7, 32'd3);
      repeat (10) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("abort/busy", 64'(busy), 64'd0);
      chk("abort/done", 64'(done), 64'd0);
      chk("abort/hilo", {hi, lo}, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      runOp("mul_7x3", 1'b0, 32'd7, 32'd3, 32'd0, 32'd21);

      runOp("div_m7d2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      runOp("div_100dm7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);
      runOp("div_preset", 1'b1, 32'h451, 32'h20, 32'h11, 32'h22);

      @(negedge clock);
      issue(1'b1, 32'd5, 32'd0);
      chk("dz/done", 64'(done), 64'd1);
      chk("dz/divz", 64'(div_zero), 64'd1);
      chk("dz/busy", 64'(busy), 64'd0);
      chk("dz/hilo", {hi, lo}, {32'h11, 32'h22});
      @(negedge clock);
      chk("dz/done_end", 64'(done), 64'd0);
      chk("dz/divz_end", 64'(div_zero), 64'd0);
      chk("dz/busy_after", 64'(busy), 64'd0);

      runOp("mul_min2", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
      runOp("div_minm1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

      // restarts while busy are dropped; the result reflects the first operands
      @(negedge clock);
      issue(1'b0, 32'd1234, 32'd5678);
      waitDone(1'b1, n, bc);
      chk("ign/latency", 64'(n), 64'd34);
      chk("ign/hilo", {hi, lo}, 64'd7006652);
      // new request in the done cycle
      issue(1'b0, 32'hFFFFFFFD, 32'hFFFFFFFC);
      waitDone(1'b0, n, bc);
      chk("b2b/latency", 64'(n), 64'd34);
      chk("b2b/hilo", {hi, lo}, 64'd12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end
endmodule
